// File: rtl/score_bcd_decoder_pkg.sv
// Shared widths, FSM encoding, 7-segment patterns and digit helpers for the score decoder.
package score_bcd_decoder_pkg;

  localparam int unsigned BIN_W       = 7;
  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned NUM_DIGITS  = 3;
  localparam int unsigned SCRATCH_W   = DIGIT_W * NUM_DIGITS;
  localparam int unsigned SEG_W       = 7;
  localparam int unsigned SHIFT_COUNT = 7;
  localparam int unsigned CNT_W       = 3;

  // Conversion sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  // Hundreds/tens/units nibbles as one packed payload
  typedef struct packed {
    logic [DIGIT_W-1:0] h;
    logic [DIGIT_W-1:0] t;
    logic [DIGIT_W-1:0] u;
  } bcd_digits_t;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // Digit to segment pattern; non-decimal codes show nothing
  function automatic logic [SEG_W-1:0] seg7_pattern(input logic [DIGIT_W-1:0] digit);
    logic [SEG_W-1:0] pat;
    pat = SEG_BLANK;
    case (digit)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

  // Double-dabble pre-shift correction: a nibble of 5 or more would exceed 9 once doubled
  function automatic logic [DIGIT_W-1:0] dd_adjust(input logic [DIGIT_W-1:0] n);
    return (n >= DIGIT_W'(5)) ? (n + DIGIT_W'(3)) : n;
  endfunction

endpackage

// File: rtl/score_bcd_decoder_seg7_encoder.sv
// Combinational BCD digit to active-low 7-segment pattern with blank override.
module score_bcd_decoder_seg7_encoder
  import score_bcd_decoder_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  input  logic               i_blank,
  output logic [SEG_W-1:0]   o_seg_c
);

  // Blank wins over the digit; codes 10-15 also decode to blank
  always_comb begin
    o_seg_c = SEG_BLANK;
    if (!i_blank) begin
      o_seg_c = seg7_pattern(i_digit);
    end
  end

endmodule

// File: rtl/score_bcd_decoder.sv
// Sequential double-dabble binary-to-BCD converter driving three blanked 7-segment displays.
module score_bcd_decoder
  import score_bcd_decoder_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [BIN_W-1:0]   bin,
  output logic               busy,
  output logic               done,
  output logic [DIGIT_W-1:0] bcd_h,
  output logic [DIGIT_W-1:0] bcd_t,
  output logic [DIGIT_W-1:0] bcd_u,
  output logic [SEG_W-1:0]   seg_h,
  output logic [SEG_W-1:0]   seg_t,
  output logic [SEG_W-1:0]   seg_u
);

  state_t                        r_state;
  logic [BIN_W-1:0]              r_shift;
  bcd_digits_t                   r_scratch;
  logic [CNT_W-1:0]              r_count;

  bcd_digits_t                   w_scratch_adj;
  logic [SCRATCH_W+BIN_W-1:0]    w_shifted;
  logic                          w_blank_h;
  logic                          w_blank_t;
  logic [SEG_W-1:0]              w_seg_h;
  logic [SEG_W-1:0]              w_seg_t;
  logic [SEG_W-1:0]              w_seg_u;

  // Correct each nibble, then shift scratch and binary together one place left
  always_comb begin
    w_scratch_adj   = '0;
    w_scratch_adj.h = dd_adjust(r_scratch.h);
    w_scratch_adj.t = dd_adjust(r_scratch.t);
    w_scratch_adj.u = dd_adjust(r_scratch.u);
    w_shifted       = {w_scratch_adj, r_shift} << 1;
  end

  // Leading-zero blanking of the finished scratch digits
  always_comb begin
    w_blank_h = (r_scratch.h == '0);
    w_blank_t = w_blank_h && (r_scratch.t == '0);
  end

  score_bcd_decoder_seg7_encoder u_seg7_encoder_h (
    .i_digit (r_scratch.h),
    .i_blank (w_blank_h),
    .o_seg_c (w_seg_h)
  );

  score_bcd_decoder_seg7_encoder u_seg7_encoder_t (
    .i_digit (r_scratch.t),
    .i_blank (w_blank_t),
    .o_seg_c (w_seg_t)
  );

  score_bcd_decoder_seg7_encoder u_seg7_encoder_u (
    .i_digit (r_scratch.u),
    .i_blank (1'b0),
    .o_seg_c (w_seg_u)
  );

  // Conversion sequencer with registered status and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_scratch <= '0;
      r_count   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd_h     <= '0;
      bcd_t     <= '0;
      bcd_u     <= '0;
      seg_h     <= SEG_BLANK;
      seg_t     <= SEG_BLANK;
      seg_u     <= SEG_0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_shift   <= bin;
            r_scratch <= '0;
            r_count   <= '0;
            busy      <= 1'b1;
            r_state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_scratch <= w_shifted[SCRATCH_W+BIN_W-1:BIN_W];
          r_shift   <= w_shifted[BIN_W-1:0];
          r_count   <= r_count + CNT_W'(1);
          if (r_count == CNT_W'(SHIFT_COUNT - 1)) begin
            r_state <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          bcd_h   <= r_scratch.h;
          bcd_t   <= r_scratch.t;
          bcd_u   <= r_scratch.u;
          seg_h   <= w_seg_h;
          seg_t   <= w_seg_t;
          seg_u   <= w_seg_u;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_bcd_decoder.sv
// Self-checking bench for score_bcd_decoder against an arithmetic decimal model.
module tb_score_bcd_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [6:0] bin;
  logic       busy;
  logic       done;
  logic [3:0] bcd_h, bcd_t, bcd_u;
  logic [6:0] seg_h, seg_t, seg_u;

  int n_vec = 0;
  int n_err = 0;

  // Expected contents of the output registers
  logic [3:0] exp_h, exp_t, exp_u;
  logic [6:0] exp_sh, exp_st, exp_su;

  localparam logic [6:0] PAT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] BLANK = 7'b1111111;

  score_bcd_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd_h (bcd_h),
    .bcd_t (bcd_t),
    .bcd_u (bcd_u),
    .seg_h (seg_h),
    .seg_t (seg_t),
    .seg_u (seg_u)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_h = 4'd0; exp_t = 4'd0; exp_u = 4'd0;
    exp_sh = BLANK; exp_st = BLANK; exp_su = PAT[0];
  endtask

  // Decimal split and blanking rules from plain arithmetic
  task automatic model_convert(input int v);
    int h, t, u;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    exp_h  = 4'(h);
    exp_t  = 4'(t);
    exp_u  = 4'(u);
    exp_sh = (h == 0) ? BLANK : PAT[h];
    exp_st = (h == 0 && t == 0) ? BLANK : PAT[t];
    exp_su = PAT[u];
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_bcd_h"}, 32'(bcd_h), 32'(exp_h));
    check({tag, "_bcd_t"}, 32'(bcd_t), 32'(exp_t));
    check({tag, "_bcd_u"}, 32'(bcd_u), 32'(exp_u));
    check({tag, "_seg_h"}, 32'(seg_h), 32'(exp_sh));
    check({tag, "_seg_t"}, 32'(seg_t), 32'(exp_st));
    check({tag, "_seg_u"}, 32'(seg_u), 32'(exp_su));
  endtask

  // Present start for one edge, then scramble bin to show it is not re-sampled
  task automatic accept(input logic [6:0] v);
    bin   = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    bin   = 7'($urandom);
    check("accept_busy", 32'(busy), 32'd1);
  endtask

  // Wait for done with a bound; optionally pulse start with bin=88 at edges +3 and +5
  task automatic wait_done(input bit glitch, output int cyc);
    cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      if (glitch && (k == 3 || k == 5)) begin
        start = 1'b1;
        bin   = 7'd88;
      end
      tick();
      start = 1'b0;
      cyc   = k;
      if (done) break;
      check("hold_busy", 32'(busy), 32'd1);
      check("hold_bcd_u", 32'(bcd_u), 32'(exp_u));
    end
  endtask

  task automatic convert(input logic [6:0] v, input bit glitch, input string tag);
    int cyc;
    accept(v);
    wait_done(glitch, cyc);
    check({tag, "_latency"}, 32'(cyc), 32'd8);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    model_convert(int'(v));
    check_outputs(tag);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    start = 1'b0;
    bin   = 7'd0;
    model_reset();
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check_outputs("rst");
    rst_n = 1'b1;
    repeat (4) tick();
    check("idle_done", 32'(done), 32'd0);
    check_outputs("idle");

    // Directed boundary values
    convert(7'd127, 1'b0, "v127");
    tick();
    check("v127_done_width", 32'(done), 32'd0);
    check_outputs("v127_hold");
    convert(7'd9, 1'b0, "v9");
    tick();
    convert(7'd100, 1'b0, "v100");
    tick();

    // Start during busy is ignored and not queued
    convert(7'd45, 1'b1, "v45_ignored");
    for (int k = 0; k < 12; k++) begin
      tick();
      check("v45_no_second_done", 32'(done), 32'd0);
    end
    check_outputs("v45_after");

    // Randomized values with scrambled bin after acceptance
    for (int i = 0; i < 24; i++) begin
      convert(7'($urandom_range(0, 127)), 1'b0, "rand");
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();

    // Reset in the middle of a conversion of 64
    accept(7'd64);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check_outputs("midrst");
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check("midrst_no_done", 32'(done), 32'd0);
    end
    check_outputs("midrst_after");

    // Back-to-back: second start presented in the done cycle of the first
    convert(7'd0, 1'b0, "b2b_0");
    accept(7'd99);
    check("b2b_done_dropped", 32'(done), 32'd0);
    wait_done(1'b0, cyc);
    check("b2b_99_latency", 32'(cyc), 32'd8);
    check("b2b_99_done", 32'(done), 32'd1);
    model_convert(99);
    check_outputs("b2b_99");
    tick();
    check("b2b_99_done_width", 32'(done), 32'd0);
    check("b2b_99_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
